// File: rtl/alu_multicycle.sv
// Multi-cycle ALU. Logic and arithmetic ops finish in one cycle. Shifts move one bit per cycle.
// MUL is an unsigned shift-add multiplier that produces a double-width product.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             alu_clk,
  input  logic             alu_rst_n,
  input  logic             alu_start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             alu_busy,
  output logic             alu_done,
  output logic [WIDTH-1:0] alu_rslt,
  output logic [WIDTH-1:0] alu_rslt_hi,
  output logic [3:0]       alu_checks
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NAND = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_XNOR = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NOTA = 4'b1000;
  localparam logic [3:0] OP_NOTB = 4'b1001;
  localparam logic [3:0] OP_SHL  = 4'b1010;
  localparam logic [3:0] OP_SHR  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rslt_q, rslt_d;
  logic [WIDTH-1:0]   rslt_hi_q, rslt_hi_d;
  logic [3:0]         checks_q, checks_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     sum_ext, diff_ext;
  logic               add_ovf, sub_ovf;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   shift_val;
  logic               shift_out;
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_psum;
  logic [2*WIDTH-1:0] prod_step;

  logic [WIDTH-1:0]   res, res_hi;
  logic               res_c, res_v, commit;

  assign sum_ext  = {1'b0, in_1} + {1'b0, in_2};
  assign diff_ext = {1'b0, in_1} - {1'b0, in_2};
  assign add_ovf  = (in_1[WIDTH-1] == in_2[WIDTH-1]) && (sum_ext[WIDTH-1] != in_1[WIDTH-1]);
  assign sub_ovf  = (in_1[WIDTH-1] != in_2[WIDTH-1]) && (diff_ext[WIDTH-1] != in_1[WIDTH-1]);
  assign shamt    = in_2[SHW-1:0];

  // Multiplier lives in the low half of prod_q and is consumed LSB-first as the product shifts in.
  assign mul_addend = prod_q[0] ? work_q : '0;
  assign mul_psum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
  assign prod_step  = {mul_psum, prod_q[WIDTH-1:1]};

  always_comb begin
    shift_val = work_q;
    shift_out = 1'b0;
    case (op_q)
      OP_SHL: begin
        shift_val = {work_q[WIDTH-2:0], 1'b0};
        shift_out = work_q[WIDTH-1];
      end
      OP_SHR: begin
        shift_val = {1'b0, work_q[WIDTH-1:1]};
        shift_out = work_q[0];
      end
      OP_SRA: begin
        shift_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        shift_out = work_q[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    work_d    = work_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    rslt_d    = rslt_q;
    rslt_hi_d = rslt_hi_q;
    checks_d  = checks_q;
    done_d    = 1'b0;
    res       = '0;
    res_hi    = '0;
    res_c     = 1'b0;
    res_v     = 1'b0;
    commit    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (alu_start) begin
          op_d = alu_ctrl;
          case (alu_ctrl)
            OP_ADD: begin
              res    = sum_ext[WIDTH-1:0];
              res_c  = sum_ext[WIDTH];
              res_v  = add_ovf;
              commit = 1'b1;
            end
            OP_SUB: begin
              res    = diff_ext[WIDTH-1:0];
              res_c  = ~diff_ext[WIDTH];
              res_v  = sub_ovf;
              commit = 1'b1;
            end
            OP_AND:  begin res = in_1 & in_2;    commit = 1'b1; end
            OP_OR:   begin res = in_1 | in_2;    commit = 1'b1; end
            OP_NAND: begin res = ~(in_1 & in_2); commit = 1'b1; end
            OP_NOR:  begin res = ~(in_1 | in_2); commit = 1'b1; end
            OP_XNOR: begin res = ~(in_1 ^ in_2); commit = 1'b1; end
            OP_XOR:  begin res = in_1 ^ in_2;    commit = 1'b1; end
            OP_NOTA: begin res = ~in_1;          commit = 1'b1; end
            OP_NOTB: begin res = ~in_2;          commit = 1'b1; end
            OP_SHL, OP_SHR, OP_SRA: begin
              if (shamt == '0) begin
                res    = in_1;
                commit = 1'b1;
              end else begin
                work_d  = in_1;
                cnt_d   = {1'b0, shamt};
                state_d = S_SHIFT;
              end
            end
            OP_MUL: begin
              work_d  = in_1;
              prod_d  = {{WIDTH{1'b0}}, in_2};
              cnt_d   = CW'(WIDTH);
              state_d = S_MUL;
            end
            default: commit = 1'b1;  // reserved: zero result, Z only
          endcase
        end
      end

      S_SHIFT: begin
        work_d = shift_val;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res     = shift_val;
          res_c   = shift_out;
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_MUL: begin
        prod_d = prod_step;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res     = prod_step[WIDTH-1:0];
          res_hi  = prod_step[2*WIDTH-1:WIDTH];
          res_c   = |prod_step[2*WIDTH-1:WIDTH];
          res_v   = |prod_step[2*WIDTH-1:WIDTH];
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // res_hi is zero for every op except MUL, so one Z rule covers all.
    if (commit) begin
      rslt_d    = res;
      rslt_hi_d = res_hi;
      checks_d  = {res_v, (res == '0) && (res_hi == '0), res_c, res[WIDTH-1]};
      done_d    = 1'b1;
    end
  end

  always_ff @(posedge alu_clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      work_q    <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      rslt_q    <= '0;
      rslt_hi_q <= '0;
      checks_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      work_q    <= work_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      rslt_q    <= rslt_d;
      rslt_hi_q <= rslt_hi_d;
      checks_q  <= checks_d;
      done_q    <= done_d;
    end
  end

  assign alu_busy    = (state_q != S_IDLE);
  assign alu_done    = done_q;
  assign alu_rslt    = rslt_q;
  assign alu_rslt_hi = rslt_hi_q;
  assign alu_checks  = checks_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized and directed bench for alu_multicycle (WIDTH=32).
// Each result is compared against an arithmetic reference model.
module tb_alu_multicycle;

  localparam int W = 32;

  logic         alu_clk;
  logic         alu_rst_n;
  logic         alu_start;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] in_1, in_2;
  logic         alu_busy, alu_done;
  logic [W-1:0] alu_rslt, alu_rslt_hi;
  logic [3:0]   alu_checks;

  int n_cmp = 0;
  int n_err = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .alu_clk     (alu_clk),
    .alu_rst_n   (alu_rst_n),
    .alu_start   (alu_start),
    .alu_ctrl    (alu_ctrl),
    .in_1        (in_1),
    .in_2        (in_2),
    .alu_busy    (alu_busy),
    .alu_done    (alu_done),
    .alu_rslt    (alu_rslt),
    .alu_rslt_hi (alu_rslt_hi),
    .alu_checks  (alu_checks)
  );

  initial alu_clk = 1'b0;
  always #5 alu_clk = ~alu_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: results from plain arithmetic on the operands, latency in edges after the launch edge.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] lo, output logic [W-1:0] hi,
                       output logic [3:0] fl, output int lat);
    logic [63:0] wide;
    longint      sa, sb, sr;
    int          s;
    logic        c, v, z;
    s   = int'(b[4:0]);
    hi  = '0;
    c   = 1'b0;
    v   = 1'b0;
    lat = 0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (op)
      4'd0: begin
        wide = {32'b0, a} + {32'b0, b};
        lo = wide[31:0]; c = wide[32];
        sr = sa + sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd1: begin
        lo = a - b; c = (a >= b);
        sr = sa - sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd2: lo = a & b;
      4'd3: lo = a | b;
      4'd4: lo = ~(a & b);
      4'd5: lo = ~(a | b);
      4'd6: lo = ~(a ^ b);
      4'd7: lo = a ^ b;
      4'd8: lo = ~a;
      4'd9: lo = ~b;
      4'd10: begin lo = a << s; c = (s != 0) ? a[32 - s] : 1'b0; lat = s; end
      4'd11: begin lo = a >> s; c = (s != 0) ? a[s - 1] : 1'b0; lat = s; end
      4'd12: begin lo = $signed(a) >>> s; c = (s != 0) ? a[s - 1] : 1'b0; lat = s; end
      4'd13: begin
        wide = {32'b0, a} * {32'b0, b};
        lo = wide[31:0]; hi = wide[63:32];
        c = (hi != 0); v = c; lat = W;
      end
      default: lo = '0;
    endcase
    z  = (lo == 0) && (hi == 0);
    fl = {v, z, c, (op >= 4'd14) ? 1'b0 : lo[31]};
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] elo, ehi, plo, phi;
    logic [3:0]   efl, pfl;
    int           elat, lat, busy_n;
    bit           held, got_done;
    model(op, a, b, elo, ehi, efl, elat);
    @(negedge alu_clk);
    plo = alu_rslt; phi = alu_rslt_hi; pfl = alu_checks; held = 1'b1;
    alu_ctrl = op; in_1 = a; in_2 = b; alu_start = 1'b1;
    @(posedge alu_clk);
    #1;
    alu_start = 1'b0;
    alu_ctrl  = 4'($urandom);
    in_1      = $urandom;
    in_2      = $urandom;
    lat = 0; busy_n = 0; got_done = 1'b0;
    while (lat <= 40) begin
      @(negedge alu_clk);
      if (alu_done) begin
        got_done = 1'b1;
        break;
      end
      if (alu_busy) busy_n++;
      if (alu_rslt !== plo || alu_rslt_hi !== phi || alu_checks !== pfl) held = 1'b0;
      @(posedge alu_clk);
      lat++;
    end
    check_eq("done_seen", 64'(got_done), 64'(1));
    check_eq("latency", 64'(lat), 64'(elat));
    check_eq("busy_cycles", 64'(busy_n), 64'(elat));
    check_eq("held_midop", 64'(held), 64'(1));
    check_eq("busy_at_done", 64'(alu_busy), 64'(0));
    check_eq("rslt", 64'(alu_rslt), 64'(elo));
    check_eq("rslt_hi", 64'(alu_rslt_hi), 64'(ehi));
    check_eq("checks", 64'(alu_checks), 64'(efl));
    $display("op=%b a=%h b=%h -> rslt=%h hi=%h checks=%b lat=%0d", op, a, b, alu_rslt, alu_rslt_hi, alu_checks, lat);
    @(negedge alu_clk);
    check_eq("done_pulse", 64'(alu_done), 64'(0));
    check_eq("rslt_hold", 64'(alu_rslt), 64'(elo));
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] corners [6];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'hFFFF_FFFF;
    corners[5] = 32'h0000_0005;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  int  lat;
  bit  got, saw_done;

  initial begin
    alu_rst_n = 1'b0;
    alu_start = 1'b0;
    alu_ctrl  = '0;
    in_1      = '0;
    in_2      = '0;
    repeat (3) @(negedge alu_clk);
    check_eq("rst_busy", 64'(alu_busy), 64'(0));
    check_eq("rst_done", 64'(alu_done), 64'(0));
    check_eq("rst_rslt", 64'(alu_rslt), 64'(0));
    check_eq("rst_checks", 64'(alu_checks), 64'(0));
    alu_rst_n = 1'b1;

    // Leave a nonzero result behind, then reset ten cycles into a MUL.
    run_op(4'b0000, 32'd5, 32'd6);
    @(negedge alu_clk);
    alu_ctrl = 4'b1101; in_1 = 32'hFFFF; in_2 = 32'h1234; alu_start = 1'b1;
    @(posedge alu_clk);
    #1 alu_start = 1'b0;
    repeat (10) @(posedge alu_clk);
    #2 alu_rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(alu_busy), 64'(0));
    check_eq("midrst_done", 64'(alu_done), 64'(0));
    check_eq("midrst_rslt", 64'(alu_rslt), 64'(0));
    check_eq("midrst_hi", 64'(alu_rslt_hi), 64'(0));
    check_eq("midrst_checks", 64'(alu_checks), 64'(0));
    repeat (2) @(negedge alu_clk);
    alu_rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge alu_clk);
      if (alu_done) saw_done = 1'b1;
    end
    check_eq("midrst_no_done", 64'(saw_done), 64'(0));
    run_op(4'b0000, 32'd1, 32'd2);

    // Directed corner cases.
    run_op(4'b0000, 32'h7FFF_FFFF, 32'h1);
    run_op(4'b0001, 32'd5, 32'd5);
    run_op(4'b0001, 32'd0, 32'd1);
    run_op(4'b1100, 32'h8000_0010, 32'd4);
    run_op(4'b1010, 32'h1, 32'd0);
    run_op(4'b1011, 32'h3, 32'd1);
    run_op(4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(4'b1101, 32'h0, 32'h1234);
    run_op(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678);

    // Start held through a MUL with changing operands, then accepted in the done cycle.
    @(negedge alu_clk);
    alu_ctrl = 4'b1101; in_1 = 32'd3; in_2 = 32'd5; alu_start = 1'b1;
    @(posedge alu_clk);
    #1;
    alu_ctrl = 4'b0000; in_1 = 32'd7; in_2 = 32'd9;
    lat = 0; got = 1'b0;
    while (lat <= 40) begin
      @(negedge alu_clk);
      if (alu_done) begin
        got = 1'b1;
        break;
      end
      @(posedge alu_clk);
      lat++;
    end
    check_eq("hold_done_seen", 64'(got), 64'(1));
    check_eq("hold_mul_lat", 64'(lat), 64'(32));
    check_eq("hold_mul_rslt", 64'(alu_rslt), 64'(15));
    check_eq("hold_mul_hi", 64'(alu_rslt_hi), 64'(0));
    @(posedge alu_clk);
    #1 alu_start = 1'b0;
    @(negedge alu_clk);
    check_eq("b2b_done", 64'(alu_done), 64'(1));
    check_eq("b2b_rslt", 64'(alu_rslt), 64'(16));
    check_eq("b2b_checks", 64'(alu_checks), 64'(0));
    $display("op=1101->0000 back-to-back: rslt=%h checks=%b", alu_rslt, alu_checks);
    @(negedge alu_clk);
    check_eq("b2b_pulse", 64'(alu_done), 64'(0));

    // Randomized sweep over every opcode.
    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom_range(0, 15)), pick_operand(), pick_operand());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
